// File: rtl/inst_fetch_if.sv
// Fetch-unit bus bundle: imem request/response, PC redirect and decoder channel.
interface inst_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;

  // Fetch unit side
  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, inst_fault,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
           redirect_valid, redirect_pc, inst_ready
  );

  // Memory / decoder / branch-logic side
  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, inst_fault,
    output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
           redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, issues one imem request at a time and
// hands each word to the decoder over valid/ready. Redirects squash any
// in-flight or held instruction; a late response after a redirect is dropped.
//
// state | meaning
// IDLE  | first cycle after reset, no request yet
// REQ   | request pc (or raise a misalignment fault without a request)
// WAIT  | request accepted, waiting for the single response
// OUT   | word held for the decoder until accepted
// HALT  | fault consumed, wait for a redirect
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input logic       clk,
  input logic       rst_n,
  inst_fetch_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_OUT  = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        fault_q, fault_d;

  logic        misaligned;
  logic        req_valid;
  logic        req_fire;

  // Request and decoder outputs are pure decodes of registered state
  assign misaligned = (pc_q[1:0] != 2'b00);
  assign req_valid  = (state_q == S_REQ) && !misaligned;
  assign req_fire   = req_valid && bus.imem_req_ready;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = (state_q == S_OUT);
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = inst_pc_q;
  assign bus.inst_fault     = fault_q;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      kill_q    <= 1'b0;
      inst_q    <= NOP_INST;
      inst_pc_q <= RESET_PC;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      kill_q    <= kill_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      fault_q   <= fault_d;
    end
  end

  // Next-state logic; a redirect takes priority in every state
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    kill_d    = kill_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    fault_d   = fault_q;
    case (state_q)
      S_IDLE: begin
        if (bus.redirect_valid) pc_d = bus.redirect_pc;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (bus.redirect_valid) begin
          pc_d = bus.redirect_pc;
          // The accepted request still gets a response; it must be dropped
          if (req_fire) begin
            kill_d  = 1'b1;
            state_d = S_WAIT;
          end
        end else if (misaligned) begin
          inst_d    = NOP_INST;
          inst_pc_d = pc_q;
          fault_d   = 1'b1;
          state_d   = S_OUT;
        end else if (req_fire) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.redirect_valid) begin
          pc_d = bus.redirect_pc;
          if (bus.imem_resp_valid) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            kill_d = 1'b1;
          end
        end else if (bus.imem_resp_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_d    = bus.imem_resp_err ? NOP_INST : bus.imem_resp_data;
            fault_d   = bus.imem_resp_err;
            inst_pc_d = pc_q;
            state_d   = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (bus.redirect_valid) begin
          pc_d    = bus.redirect_pc;
          state_d = S_REQ;
        end else if (bus.inst_ready) begin
          if (fault_q) begin
            state_d = S_HALT;
          end else begin
            pc_d    = pc_q + 32'd4;
            state_d = S_REQ;
          end
        end
      end
      S_HALT: begin
        if (bus.redirect_valid) begin
          pc_d    = bus.redirect_pc;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: memory model plus a transaction-level reference that
// tracks only the architectural next-fetch PC and whether fetch is halted.
module tb_inst_fetch;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  inst_fetch_if bus();

  inst_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory contents: distinct word per address, fault at chosen addresses
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0050_0093 ^ {a[15:0], 16'h0000};
  endfunction
  function automatic logic err_at(input logic [31:0] a);
    return (a == 32'h8000_0010) || (a[31:28] != 4'h8 && a[5:2] == 4'hB);
  endfunction
  function automatic logic exp_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || err_at(a);
  endfunction
  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return exp_fault(a) ? NOP_INST : mem_word(a);
  endfunction

  // Reference state
  logic [31:0] exp_pc = RESET_PC;
  bit          halted = 1'b0;
  bit          pending = 1'b0;
  int          cnt = 0;
  logic [31:0] pend_addr = '0;
  int          mem_delay = 0;

  // Stimulus knobs
  bit          st_redir = 1'b0;
  logic [31:0] st_rpc = '0;
  bit          st_req_rdy = 1'b0;
  bit          st_inst_rdy = 1'b0;

  // Per-step samples and statistics
  logic        s_rv, s_iv, s_if;
  logic [31:0] s_ra, s_inst, s_ipc;
  bit          req_fire, inst_fire;
  int          cyc = 0, n_req = 0, n_inst = 0;
  logic [31:0] last_req_addr = '0;

  task automatic reset_model();
    exp_pc  = RESET_PC;
    halted  = 1'b0;
    pending = 1'b0;
    cnt     = 0;
    bus.imem_resp_valid = 1'b0;
  endtask

  // One clock: sample at negedge, check against reference, drive inputs, advance reference
  task automatic step();
    @(negedge clk);
    cyc++;
    s_rv = bus.imem_req_valid; s_ra = bus.imem_req_addr;
    s_iv = bus.inst_valid; s_inst = bus.inst; s_ipc = bus.inst_pc; s_if = bus.inst_fault;
    if (rst_n) begin
      if (halted) begin
        check_val("halt_no_req", 32'(s_rv), 32'd0);
        check_val("halt_no_inst", 32'(s_iv), 32'd0);
      end
      if (pending) check_val("req_while_outstanding", 32'(s_rv), 32'd0);
      if (exp_pc[1:0] != 2'b00) check_val("misaligned_no_req", 32'(s_rv), 32'd0);
      if (s_rv) begin
        check_val("req_addr", s_ra, exp_pc);
        check_val("req_during_out", 32'(s_iv), 32'd0);
      end
      if (s_iv) begin
        check_val("inst_pc", s_ipc, exp_pc);
        check_val("inst_word", s_inst, exp_word(exp_pc));
        check_val("inst_fault", 32'(s_if), 32'(exp_fault(exp_pc)));
      end
    end
    bus.redirect_valid = st_redir;
    bus.redirect_pc    = st_rpc;
    bus.imem_req_ready = st_req_rdy;
    bus.inst_ready     = st_inst_rdy;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = $urandom;
    bus.imem_resp_err   = 1'b0;
    if (pending) begin
      if (cnt == 0) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = mem_word(pend_addr);
        bus.imem_resp_err   = err_at(pend_addr);
        pending = 1'b0;
      end else begin
        cnt--;
      end
    end
    req_fire  = rst_n && s_rv && st_req_rdy;
    inst_fire = rst_n && s_iv && st_inst_rdy && !st_redir;
    if (req_fire) begin
      pending = 1'b1;
      cnt = mem_delay;
      pend_addr = s_ra;
      n_req++;
      last_req_addr = s_ra;
    end
    if (rst_n) begin
      if (st_redir) begin
        exp_pc = st_rpc;
        halted = 1'b0;
      end else if (inst_fire) begin
        n_inst++;
        if (exp_fault(exp_pc)) halted = 1'b1;
        else exp_pc = exp_pc + 32'd4;
      end
    end
  endtask

  task automatic wait_req(input int max, input string tag);
    int k = 0;
    do begin step(); k++; end while (!req_fire && k < max);
    check_val({tag, "_req_seen"}, 32'(req_fire), 32'd1);
  endtask

  task automatic wait_inst(input int max, input string tag);
    int k = 0;
    do begin step(); k++; end while (!s_iv && k < max);
    check_val({tag, "_inst_seen"}, 32'(s_iv), 32'd1);
  endtask

  task automatic redirect_to(input logic [31:0] target);
    st_redir = 1'b1; st_rpc = target;
    step();
    st_redir = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'd0);
    check_val({tag, "_inst_valid"}, 32'(bus.inst_valid), 32'd0);
    check_val({tag, "_inst"}, bus.inst, NOP_INST);
    check_val({tag, "_inst_pc"}, bus.inst_pc, RESET_PC);
    check_val({tag, "_inst_fault"}, 32'(bus.inst_fault), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int prev, n0;
    logic [31:0] hold_pc, hold_w;
    bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data = '0;   bus.imem_resp_err = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    bus.inst_ready = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1; cyc = 0;

    // Straight-line fetch, zero-wait memory, one instruction per three cycles
    st_req_rdy = 1'b1; st_inst_rdy = 1'b1; mem_delay = 0;
    wait_req(5, "t1a");
    check_val("t1_first_req_cycle", cyc, 32'd1);
    check_val("t1_addr0", last_req_addr, 32'h8000_0000);
    prev = cyc;
    wait_req(5, "t1b");
    check_val("t1_period1", cyc - prev, 32'd3);
    check_val("t1_addr1", last_req_addr, 32'h8000_0004);
    prev = cyc;
    wait_req(5, "t1c");
    check_val("t1_period2", cyc - prev, 32'd3);
    check_val("t1_addr2", last_req_addr, 32'h8000_0008);

    // Decoder stall: held word stable, no new requests
    st_inst_rdy = 1'b0;
    wait_inst(8, "t2");
    hold_pc = s_ipc; hold_w = s_inst;
    check_val("t2_pc", s_ipc, 32'h8000_0008);
    repeat (5) begin
      step();
      check_val("t2_valid_held", 32'(s_iv), 32'd1);
      check_val("t2_pc_stable", s_ipc, hold_pc);
      check_val("t2_inst_stable", s_inst, hold_w);
      check_val("t2_no_req", 32'(s_rv), 32'd0);
    end
    st_inst_rdy = 1'b1;
    step();

    // Redirect while waiting; the late response must be discarded
    mem_delay = 2;
    wait_req(8, "t3a");
    check_val("t3_req_before", last_req_addr, 32'h8000_000C);
    n0 = n_inst;
    redirect_to(32'h8000_0100);
    mem_delay = 0;
    wait_req(8, "t3b");
    check_val("t3_req_after", last_req_addr, 32'h8000_0100);
    wait_inst(8, "t3c");
    check_val("t3_inst_pc", s_ipc, 32'h8000_0100);
    check_val("t3_one_inst", n_inst - n0, 32'd1);

    // Access fault then halt, resumed by redirect
    redirect_to(32'h8000_0010);
    wait_inst(8, "t4a");
    check_val("t4_inst", s_inst, NOP_INST);
    check_val("t4_fault", 32'(s_if), 32'd1);
    check_val("t4_pc", s_ipc, 32'h8000_0010);
    n0 = n_req;
    repeat (10) step();
    check_val("t4_halt_reqs", n_req - n0, 32'd0);
    redirect_to(32'h8000_0000);
    wait_req(8, "t4b");
    check_val("t4_resume_addr", last_req_addr, 32'h8000_0000);

    // Misaligned redirect: fault without a memory request
    redirect_to(32'h8000_0002);
    n0 = n_req;
    wait_inst(8, "t5");
    check_val("t5_fault", 32'(s_if), 32'd1);
    check_val("t5_pc", s_ipc, 32'h8000_0002);
    check_val("t5_inst", s_inst, NOP_INST);
    check_val("t5_no_req", n_req - n0, 32'd0);

    // PC wrap, then asynchronous reset while waiting
    redirect_to(32'hFFFF_FFFC);
    wait_inst(8, "t6a");
    check_val("t6_pc_top", s_ipc, 32'hFFFF_FFFC);
    mem_delay = 5;
    wait_req(8, "t6b");
    check_val("t6_wrap_addr", last_req_addr, 32'h0000_0000);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    reset_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1; cyc = 0; mem_delay = 0;
    wait_req(5, "t6c");
    check_val("t6_refetch_cycle", cyc, 32'd1);
    check_val("t6_refetch_addr", last_req_addr, RESET_PC);

    // Randomized traffic against the reference
    n0 = n_inst;
    for (int i = 0; i < 3000; i++) begin
      int r;
      st_redir = halted ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      r = $urandom_range(0, 15);
      if (r == 0)      st_rpc = 32'h1000_0002 + (32'($urandom_range(0, 63)) << 2);
      else if (r == 1) st_rpc = 32'hFFFF_FFFC;
      else if (r == 2) st_rpc = 32'h8000_0010;
      else             st_rpc = 32'h1000_0000 + (32'($urandom_range(0, 63)) << 2);
      st_req_rdy  = ($urandom_range(0, 9) < 7);
      st_inst_rdy = ($urandom_range(0, 9) < 7);
      mem_delay   = $urandom_range(0, 3);
      step();
    end
    check_val("rand_progress", 32'(n_inst - n0 > 100), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
